// File: rtl/move_seq_pkg.sv
// Shared definitions for the 2048 move sequencer: direction codes, FSM encoding, LFSR constants.
package move_seq_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_MOVE_REQ   = 3'd1,
    S_MOVE_WAIT  = 3'd2,
    S_SPAWN_REQ  = 3'd3,
    S_SPAWN_WAIT = 3'd4
  } state_t;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'h01;

  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-button debouncer: level follows raw after DEBOUNCE_CYCLES stable cycles; press pulses on its rise.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [15:0] cnt;

  // press is set on the same edge that flips level, so both are high in the first cycle of the new level
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      level <= 1'b0;
      press <= 1'b0;
      cnt   <= 16'd0;
    end else begin
      press <= 1'b0;
      if (raw != level) begin
        if (cnt == LAST) begin
          level <= raw;
          press <= raw;
          cnt   <= 16'd0;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end else begin
        cnt <= 16'd0;
      end
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// Debounces direction buttons, arbitrates presses and sequences the board engine through move and spawn.
// Optional one-entry press queue is built when MOVE_QUEUE_EN is defined.
//
// state      | meaning
// IDLE       | waiting for a press event
// MOVE_REQ   | move_valid high until move_ready
// MOVE_WAIT  | waiting for move_done
// SPAWN_REQ  | spawn_valid high until spawn_ready
// SPAWN_WAIT | waiting for spawn_done
module move_sequencer
  import move_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        game_over,
  output logic        move_valid,
  output logic [1:0]  move_dir,
  input  logic        move_ready,
  input  logic        move_done,
  input  logic        move_changed,
  output logic        spawn_valid,
  output logic [3:0]  spawn_seed,
  input  logic        spawn_ready,
  input  logic        spawn_done,
  output logic        busy,
  output logic [15:0] move_count
);

  logic [3:0] raw;
  logic [3:0] level;
  logic [3:0] press;
  logic [3:0] evt;
  logic       evt_valid;
  dir_t       evt_dir;
  state_t     state, state_next;
  logic       issue;
  dir_t       issue_dir;
  logic [7:0] lfsr;

  assign raw = {btn_right, btn_left, btn_down, btn_up};

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .Clk(Clk), .Reset_n(Reset_n), .raw(raw[0]), .level(level[0]), .press(press[0]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .Clk(Clk), .Reset_n(Reset_n), .raw(raw[1]), .level(level[1]), .press(press[1]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .Clk(Clk), .Reset_n(Reset_n), .raw(raw[2]), .level(level[2]), .press(press[2]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .Clk(Clk), .Reset_n(Reset_n), .raw(raw[3]), .level(level[3]), .press(press[3]));

  assign evt = press & level;

  always_comb begin
    evt_valid = |evt;
    if (evt[0])      evt_dir = DIR_UP;
    else if (evt[1]) evt_dir = DIR_DOWN;
    else if (evt[2]) evt_dir = DIR_LEFT;
    else             evt_dir = DIR_RIGHT;
  end

`ifdef MOVE_QUEUE_EN
  logic q_valid;
  dir_t q_dir;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      q_valid <= 1'b0;
      q_dir   <= DIR_UP;
    end else if (state == S_IDLE) begin
      if (game_over) begin
        q_valid <= 1'b0;
      end else if (q_valid) begin
        // queued entry issues now; a same-cycle new event takes its slot
        q_valid <= evt_valid;
        q_dir   <= evt_dir;
      end
    end else if (evt_valid && !q_valid) begin
      q_valid <= 1'b1;
      q_dir   <= evt_dir;
    end
  end
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    issue_dir  = evt_dir;
    case (state)
      S_IDLE: begin
        if (!game_over) begin
`ifdef MOVE_QUEUE_EN
          if (q_valid) begin
            issue     = 1'b1;
            issue_dir = q_dir;
          end else begin
            issue = evt_valid;
          end
`else
          issue = evt_valid;
`endif
        end
        if (issue) state_next = S_MOVE_REQ;
      end
      S_MOVE_REQ:   if (move_ready) state_next = S_MOVE_WAIT;
      S_MOVE_WAIT:  if (move_done)  state_next = move_changed ? S_SPAWN_REQ : S_IDLE;
      S_SPAWN_REQ:  if (spawn_ready) state_next = S_SPAWN_WAIT;
      S_SPAWN_WAIT: if (spawn_done) state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  always_comb begin
    move_valid  = (state == S_MOVE_REQ);
    spawn_valid = (state == S_SPAWN_REQ);
    busy        = (state != S_IDLE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lfsr       <= LFSR_SEED;
      move_dir   <= 2'b00;
      spawn_seed <= 4'h0;
      move_count <= 16'h0000;
    end else begin
      lfsr <= lfsr_step(lfsr);
      if (issue) move_dir <= issue_dir;
      if (state == S_MOVE_WAIT && move_done && move_changed) begin
        spawn_seed <= lfsr[3:0];
        if (move_count != 16'hFFFF) move_count <= move_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed self-checking bench for move_sequencer with DEBOUNCE_CYCLES=4.
module tb_move_sequencer;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        btn_up, btn_down, btn_left, btn_right;
  logic        game_over;
  logic        move_valid;
  logic [1:0]  move_dir;
  logic        move_ready, move_done, move_changed;
  logic        spawn_valid;
  logic [3:0]  spawn_seed;
  logic        spawn_ready, spawn_done;
  logic        busy;
  logic [15:0] move_count;

  int checks = 0;
  int errors = 0;
  logic       seen;
  logic [3:0] exp_seed;
  logic [7:0] m_lfsr;

  move_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .game_over(game_over),
    .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
    .move_done(move_done), .move_changed(move_changed),
    .spawn_valid(spawn_valid), .spawn_seed(spawn_seed), .spawn_ready(spawn_ready),
    .spawn_done(spawn_done), .busy(busy), .move_count(move_count)
  );

  always #5 Clk = ~Clk;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, Galois, seeded 8'h01
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) m_lfsr <= 8'h01;
    else          m_lfsr <= {1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    game_over = 0; move_ready = 1; move_done = 0; move_changed = 0;
    spawn_ready = 0; spawn_done = 0;
    #3;
    chk("rst_move_valid", move_valid, 0);
    chk("rst_spawn_valid", spawn_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_move_dir", move_dir, 0);
    chk("rst_spawn_seed", spawn_seed, 0);
    chk("rst_move_count", move_count, 0);
    #9 Reset_n = 1'b1;
    tick(); tick();

    // Up press: cycle 0 raw high, request in cycle 5
    btn_up = 1;
    seen = 0;
    repeat (4) begin tick(); if (move_valid) seen = 1; end
    chk("t1_early_valid", seen, 0);
    tick();
    chk("t1_valid", move_valid, 1);
    chk("t1_dir", move_dir, 2'b00);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_valid_drop", move_valid, 0);
    move_done = 1; move_changed = 1; exp_seed = m_lfsr[3:0]; btn_up = 0;
    tick();
    move_done = 0; move_changed = 0;
    chk("t1_spawn_valid", spawn_valid, 1);
    chk("t1_count", move_count, 1);
    chk("t1_seed", spawn_seed, exp_seed);
    tick();
    chk("t1_spawn_hold", spawn_valid, 1);
    chk("t1_seed_hold", spawn_seed, exp_seed);
    spawn_ready = 1;
    tick();
    spawn_ready = 0;
    chk("t1_spawn_drop", spawn_valid, 0);
    chk("t1_busy_wait", busy, 1);
    spawn_done = 1;
    tick();
    spawn_done = 0;
    chk("t1_idle", busy, 0);
    repeat (6) tick();
    spawn_ready = 1;

    // Bouncing right button never settles
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      btn_right = (i % 2 == 0);
      repeat (2) begin tick(); if (move_valid || busy) seen = 1; end
    end
    repeat (6) begin tick(); if (move_valid || busy) seen = 1; end
    chk("t2_bounce", seen, 0);

    // Left and down together: down wins; unchanged move skips spawn
    btn_left = 1; btn_down = 1;
    repeat (5) tick();
    chk("t3_valid", move_valid, 1);
    chk("t3_dir", move_dir, 2'b01);
    tick();
    chk("t3_valid_drop", move_valid, 0);
    move_done = 1; move_changed = 0;
    tick();
    move_done = 0;
    chk("t4_idle", busy, 0);
    chk("t4_no_spawn", spawn_valid, 0);
    chk("t4_count", move_count, 1);
    btn_left = 0; btn_down = 0;
    seen = 0;
    repeat (8) begin tick(); if (move_valid || spawn_valid) seen = 1; end
    chk("t3_single_req", seen, 0);

    // game_over blocks new presses
    game_over = 1; btn_up = 1;
    seen = 0;
    repeat (10) begin tick(); if (move_valid || busy) seen = 1; end
    chk("t5_blocked", seen, 0);
    btn_up = 0;
    repeat (6) tick();
    game_over = 0;

    // game_over rising mid-sequence does not abort it
    btn_down = 1;
    repeat (5) tick();
    chk("t5_valid", move_valid, 1);
    chk("t5_dir", move_dir, 2'b01);
    game_over = 1;
    tick();
    move_done = 1; move_changed = 1;
    tick();
    move_done = 0; move_changed = 0;
    chk("t5_spawn", spawn_valid, 1);
    chk("t5_count", move_count, 2);
    tick();
    chk("t5_spawn_drop", spawn_valid, 0);
    spawn_done = 1;
    tick();
    spawn_done = 0;
    chk("t5_idle", busy, 0);
    game_over = 0; btn_down = 0;
    repeat (6) tick();

    // Down pressed while busy: queued or discarded depending on build
    btn_up = 1;
    repeat (3) tick();
    btn_down = 1;
    repeat (2) tick();
    chk("t7_valid", move_valid, 1);
    chk("t7_dir", move_dir, 2'b00);
    tick();
    move_done = 1; move_changed = 1;
    tick();
    move_done = 0; move_changed = 0;
    chk("t7_spawn", spawn_valid, 1);
    tick();
    spawn_done = 1;
    tick();
    spawn_done = 0;
    chk("t7_idle", busy, 0);
    chk("t7_idle_valid", move_valid, 0);
    tick();
`ifdef MOVE_QUEUE_EN
    chk("t7_queued_valid", move_valid, 1);
    chk("t7_queued_dir", move_dir, 2'b01);
    tick();
    move_done = 1; move_changed = 0;
    tick();
    move_done = 0;
    chk("t7_queued_idle", busy, 0);
`else
    chk("t7_discard_valid", move_valid, 0);
    chk("t7_discard_busy", busy, 0);
`endif
    btn_up = 0; btn_down = 0;
    repeat (6) tick();

    // Reset during SPAWN_REQ
    spawn_ready = 0;
    btn_left = 1;
    repeat (5) tick();
    chk("t6_valid", move_valid, 1);
    chk("t6_dir", move_dir, 2'b10);
    tick();
    move_done = 1; move_changed = 1;
    tick();
    move_done = 0; move_changed = 0;
    chk("t6_spawn", spawn_valid, 1);
    chk("t6_count", move_count, 4);
    btn_left = 0;
    #2 Reset_n = 1'b0;
    #1;
    chk("t6_rst_spawn", spawn_valid, 0);
    chk("t6_rst_move_valid", move_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_count", move_count, 0);
    chk("t6_rst_dir", move_dir, 0);
    chk("t6_rst_seed", spawn_seed, 0);
    #3 Reset_n = 1'b1;
    tick(); tick();
    chk("t6_post_busy", busy, 0);
    chk("t6_post_spawn", spawn_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
